// File: rtl/pll_reconfig_sequencer.sv
// Purpose : runs one PLL M/N/C reconfiguration per request: trigger, wait for stable, wait for settled lock, ack.
// Latency : outputs registered; first pll_trigger 1 cycle after acceptance, ack 1 cycle after lock settles.
// Backpressure: req_ready high only in IDLE; a timed-out attempt is re-triggered up to MAX_RETRIES times.
//
// Ports:
//   clock, reset_n                 system clock, synchronous active-low reset
//   req_valid/req_ready/req_m/n/c  request handshake and requested counter values
//   ack/ack_err                    one-cycle completion pulse, error = timed out after all retries
//   busy/fifo_hold                 high from the cycle after acceptance through the ack cycle
//   pll_m/n/c, pll_trigger         to the PLL interface (values held between acceptances)
//   pll_locked, pll_stable         from the PLL interface, already synchronous to clock
//
// Optional feature: define PLL_SEQ_SKIP_SAME_EN to complete a request immediately (no trigger)
// when it repeats the values already applied by the last successful request.
module pll_reconfig_sequencer #(
  parameter int PLL_DATA_WIDTH = 8,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SETTLE_CYCLES  = 16,
  parameter int MAX_RETRIES    = 2,
  parameter logic [PLL_DATA_WIDTH-1:0] DEF_M = PLL_DATA_WIDTH'(1),
  parameter logic [PLL_DATA_WIDTH-1:0] DEF_N = PLL_DATA_WIDTH'(1),
  parameter logic [PLL_DATA_WIDTH-1:0] DEF_C = PLL_DATA_WIDTH'(1)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [PLL_DATA_WIDTH-1:0] req_m,
  input  logic [PLL_DATA_WIDTH-1:0] req_n,
  input  logic [PLL_DATA_WIDTH-1:0] req_c,
  output logic                      ack,
  output logic                      ack_err,
  output logic                      busy,
  output logic                      fifo_hold,
  output logic [PLL_DATA_WIDTH-1:0] pll_m,
  output logic [PLL_DATA_WIDTH-1:0] pll_n,
  output logic [PLL_DATA_WIDTH-1:0] pll_c,
  output logic                      pll_trigger,
  input  logic                      pll_locked,
  input  logic                      pll_stable
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int RETRY_W  = $clog2(MAX_RETRIES + 2);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LIMIT    = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [SETTLE_W-1:0]      SETTLE_LIMIT = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [RETRY_W-1:0]       RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  // The PLL interface needs two cycles after the trigger before pll_stable means anything.
  localparam logic [1:0]               STB_IGNORE   = 2'd2;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_STB, WAIT_LCK, DONE} state_t;

  state_t                      state_q, state_d;
  logic [PLL_DATA_WIDTH-1:0]   pll_m_q, pll_m_d, pll_n_q, pll_n_d, pll_c_q, pll_c_d;
  logic [RETRY_W-1:0]          retry_q, retry_d;
  logic [TIMEOUT_WIDTH-1:0]    tmo_q, tmo_d;
  logic [SETTLE_W-1:0]         settle_q, settle_d;
  logic [1:0]                  stb_wait_q, stb_wait_d;
  logic                        req_ready_q, req_ready_d;
  logic                        ack_q, ack_d, ack_err_q, ack_err_d;
  logic                        busy_q, busy_d, fifo_hold_q, fifo_hold_d;
  logic                        pll_trigger_q, pll_trigger_d;
`ifdef PLL_SEQ_SKIP_SAME_EN
  // Set only once a request has completed without error since reset.
  logic                        applied_ok_q, applied_ok_d;
`endif

  logic [TIMEOUT_WIDTH-1:0]    tmo_inc;
  logic [SETTLE_W-1:0]         settle_inc;
  logic                        tmo_hit, settle_done, done_err;

  always_comb begin
    // Saturating timeout count so a very long wait can never wrap back below the limit.
    tmo_inc     = (tmo_q == {TIMEOUT_WIDTH{1'b1}}) ? tmo_q : tmo_q + TIMEOUT_WIDTH'(1);
    tmo_hit     = (tmo_inc >= TMO_LIMIT);
    settle_inc  = settle_q + SETTLE_W'(1);
    settle_done = pll_locked && (settle_inc == SETTLE_LIMIT);

    state_d    = state_q;
    pll_m_d    = pll_m_q;
    pll_n_d    = pll_n_q;
    pll_c_d    = pll_c_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    settle_d   = settle_q;
    stb_wait_d = stb_wait_q;
    done_err   = 1'b0;
`ifdef PLL_SEQ_SKIP_SAME_EN
    applied_ok_d = applied_ok_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          pll_m_d = req_m;
          pll_n_d = req_n;
          pll_c_d = req_c;
          retry_d = '0;
          state_d = TRIG;
`ifdef PLL_SEQ_SKIP_SAME_EN
          if (applied_ok_q && (req_m == pll_m_q) && (req_n == pll_n_q) && (req_c == pll_c_q)) begin
            state_d = DONE;
          end
`endif
        end
      end
      TRIG: begin
        tmo_d      = '0;
        settle_d   = '0;
        stb_wait_d = '0;
        state_d    = WAIT_STB;
      end
      WAIT_STB: begin
        tmo_d = tmo_inc;
        if (stb_wait_q != STB_IGNORE) begin
          stb_wait_d = stb_wait_q + 2'd1;
        end else if (pll_stable) begin
          state_d = WAIT_LCK;
        end
      end
      WAIT_LCK: begin
        tmo_d    = tmo_inc;
        settle_d = pll_locked ? settle_inc : '0;
        if (settle_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout overrides the wait states, except that a settle completing in the same cycle wins.
    if (((state_q == WAIT_STB) || ((state_q == WAIT_LCK) && !settle_done)) && tmo_hit) begin
      if (retry_q < RETRY_LIMIT) begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = TRIG;
      end else begin
        state_d  = DONE;
        done_err = 1'b1;
      end
    end

`ifdef PLL_SEQ_SKIP_SAME_EN
    if ((state_d == DONE) && (state_q != DONE)) begin
      applied_ok_d = !done_err;
    end
`endif

    // Outputs are a registered decode of the next state.
    req_ready_d   = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    fifo_hold_d   = (state_d != IDLE);
    ack_d         = (state_d == DONE);
    ack_err_d     = (state_d == DONE) && done_err;
    pll_trigger_d = (state_d == TRIG);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pll_m_q       <= DEF_M;
      pll_n_q       <= DEF_N;
      pll_c_q       <= DEF_C;
      retry_q       <= '0;
      tmo_q         <= '0;
      settle_q      <= '0;
      stb_wait_q    <= '0;
      req_ready_q   <= 1'b1;
      ack_q         <= 1'b0;
      ack_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      fifo_hold_q   <= 1'b0;
      pll_trigger_q <= 1'b0;
`ifdef PLL_SEQ_SKIP_SAME_EN
      applied_ok_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pll_m_q       <= pll_m_d;
      pll_n_q       <= pll_n_d;
      pll_c_q       <= pll_c_d;
      retry_q       <= retry_d;
      tmo_q         <= tmo_d;
      settle_q      <= settle_d;
      stb_wait_q    <= stb_wait_d;
      req_ready_q   <= req_ready_d;
      ack_q         <= ack_d;
      ack_err_q     <= ack_err_d;
      busy_q        <= busy_d;
      fifo_hold_q   <= fifo_hold_d;
      pll_trigger_q <= pll_trigger_d;
`ifdef PLL_SEQ_SKIP_SAME_EN
      applied_ok_q  <= applied_ok_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign ack         = ack_q;
  assign ack_err     = ack_err_q;
  assign busy        = busy_q;
  assign fifo_hold   = fifo_hold_q;
  assign pll_m       = pll_m_q;
  assign pll_n       = pll_n_q;
  assign pll_c       = pll_c_q;
  assign pll_trigger = pll_trigger_q;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Purpose : randomized scoreboard bench for pll_reconfig_sequencer with a behavioural PLL responder.
// Latency : expected ack cycle is computed from the trigger/stable/lock timing rules.
// Backpressure: requester holds req_valid until req_ready; monitor checks every ack against the queue.
module tb_pll_reconfig_sequencer;

  localparam int TMO     = 100;
  localparam int SETTLE  = 16;
  localparam int RETRIES = 2;
`ifdef PLL_SEQ_SKIP_SAME_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready;
  logic [7:0] req_m, req_n, req_c;
  logic       ack, ack_err, busy, fifo_hold;
  logic [7:0] pll_m, pll_n, pll_c;
  logic       pll_trigger, pll_locked, pll_stable;

  always #5 clock = ~clock;

  pll_reconfig_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_m(req_m), .req_n(req_n), .req_c(req_c),
    .ack(ack), .ack_err(ack_err), .busy(busy), .fifo_hold(fifo_hold),
    .pll_m(pll_m), .pll_n(pll_n), .pll_c(pll_c),
    .pll_trigger(pll_trigger), .pll_locked(pll_locked), .pll_stable(pll_stable)
  );

  typedef struct {
    int acc; int ack_cyc; int err; int trigs; int m; int n; int c;
  } exp_t;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Cycle (counted from the trigger cycle = 0) in which the 16th consecutive locked cycle is seen.
  function automatic int settle_done_at(input int s, input int l, input int g);
    int ts, start, tg;
    ts    = (s > 3) ? s : 3;                 // pll_stable first honoured 3 cycles after the trigger
    start = (ts + 1 > s + l) ? ts + 1 : s + l;
    if (g > 0) begin
      tg = s + l + g;
      if (tg >= start) start = tg + 1;
    end
    return start + SETTLE - 1;
  endfunction

  function automatic exp_t predict(input int acc, input int m, input int n, input int c,
                                   input int f, input int s, input int l, input int g,
                                   input bit skip);
    exp_t e;
    int   tc;
    e.acc = acc; e.m = m; e.n = n; e.c = c;
    if (skip) begin
      e.ack_cyc = acc + 1; e.err = 0; e.trigs = 0;
      return e;
    end
    e.err     = 1;
    e.trigs   = RETRIES + 1;
    e.ack_cyc = acc + 1 + RETRIES * (TMO + 1) + TMO + 1;
    for (int a = 0; a <= RETRIES; a++) begin
      if (a >= f) begin
        tc = settle_done_at(s, l, g);
        if (tc <= TMO) begin
          e.err     = 0;
          e.trigs   = a + 1;
          e.ack_cyc = acc + 1 + a * (TMO + 1) + tc + 1;
          return e;
        end
      end
    end
    return e;
  endfunction

  // ---------------- PLL responder ----------------
  int req_id = 0, model_id = -1, attempt = 0, t = 100000;
  int p_f = 0, p_s = 0, p_l = 0, p_g = 0;

  always @(negedge clock) begin
    if (pll_trigger === 1'b1) begin
      t = 0;
      if (model_id != req_id) begin
        model_id = req_id;
        attempt  = 0;
      end else begin
        attempt++;
      end
    end else if (t < 100000) begin
      t++;
    end
    if (attempt < p_f) begin
      pll_stable = 1'b0;
      pll_locked = 1'b0;
    end else begin
      pll_stable = (t >= p_s);
      pll_locked = (t >= p_s + p_l) && !(p_g > 0 && t == p_s + p_l + p_g);
    end
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  int   hold_len = 0, trig_cnt = 0;
  bit   post_chk = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      hold_len = 0;
      trig_cnt = 0;
      post_chk = 1'b0;
    end else begin
      if (post_chk) begin
        chk("post_ack_ack_hold_ready_busy", {ack, fifo_hold, req_ready, busy}, 4'b0010);
        post_chk = 1'b0;
      end
      if (fifo_hold) hold_len++; else hold_len = 0;
      if (pll_trigger) trig_cnt++;
      if (ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_cycle", cyc, mon_e.ack_cyc);
          chk("ack_err", ack_err, mon_e.err);
          chk("trigger_count", trig_cnt, mon_e.trigs);
          chk("fifo_hold_span", hold_len, mon_e.ack_cyc - mon_e.acc);
          chk("pll_m", pll_m, mon_e.m);
          chk("pll_n", pll_n, mon_e.n);
          chk("pll_c", pll_c, mon_e.c);
        end
        trig_cnt = 0;
        post_chk = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  int cur_m = 1, cur_n = 1, cur_c = 1;
  bit last_ok = 1'b0;

  task automatic check_idle_defaults(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fifo_hold"}, fifo_hold, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_ack_err"}, ack_err, 0);
    chk({tag, "_pll_trigger"}, pll_trigger, 0);
    chk({tag, "_pll_m"}, pll_m, 1);
    chk({tag, "_pll_n"}, pll_n, 1);
    chk({tag, "_pll_c"}, pll_c, 1);
  endtask

  // Issue one request at the current negedge; return at the negedge where ack is seen
  // (or where reset is released when abort_at >= 0 cycles after acceptance).
  task automatic issue(input int m, input int n, input int c, input int f,
                       input int s, input int l, input int g, input int abort_at);
    int   acc;
    bit   accepted, skip;
    exp_t e;
    p_f = f; p_s = s; p_l = l; p_g = g;
    req_id++;
    req_valid = 1'b1;
    req_m = 8'(m); req_n = 8'(n); req_c = 8'(c);
    accepted = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!accepted) begin
      chk("accept_wait", 0, 1);
      req_valid = 1'b0;
      return;
    end
    acc  = cyc;
    skip = SKIP_EN && last_ok && (m == cur_m) && (n == cur_n) && (c == cur_c);
    e    = predict(acc, m, n, c, f, s, l, g, skip);
    sb.push_back(e);
    cur_m = m; cur_n = n; cur_c = c;
    last_ok = (e.err == 0);
    @(negedge clock);
    req_valid = 1'b0;
    req_m = 8'($urandom); req_n = 8'($urandom); req_c = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      if (abort_at >= 0 && cyc == acc + abort_at) begin
        reset_n = 1'b0;
        @(negedge clock);
        check_idle_defaults("mid_reset");
        sb.delete();
        cur_m = 1; cur_n = 1; cur_c = 1;
        last_ok = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
      if (ack) return;
      @(negedge clock);
    end
    chk("ack_wait", 0, 1);
  endtask

  task automatic gap_then_issue(input int m, input int n, input int c, input int f,
                                input int s, input int l, input int g);
    repeat ($urandom_range(0, 2)) @(negedge clock);
    issue(m, n, c, f, s, l, g, -1);
  endtask

  initial begin
    int m, n, c, f, s, l, g;
    reset_n = 1'b0; req_valid = 1'b0;
    req_m = 8'd0; req_n = 8'd0; req_c = 8'd0;
    pll_stable = 1'b0; pll_locked = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle_defaults("reset");
    reset_n = 1'b1;
    @(negedge clock);

    gap_then_issue(8, 2, 4, 0, 5, 10, 0);     // normal reconfig
    gap_then_issue(9, 3, 5, 0, 5, 10, 10);    // lock glitch after 10 locked cycles
    gap_then_issue(9, 3, 5, 0, 5, 10, 0);     // same values again (skipped when feature enabled)
    gap_then_issue(7, 7, 7, 3, 0, 0, 0);      // stable never rises: 3 attempts then error
    gap_then_issue(7, 7, 7, 0, 2, 0, 0);      // same values after an error: full sequence
    gap_then_issue(20, 4, 2, 0, 3, 82, 0);    // settle completes on the timeout cycle
    gap_then_issue(21, 4, 2, 0, 3, 83, 0);    // settle one cycle too late: error
    gap_then_issue(22, 5, 1, 1, 0, 0, 0);     // one retry then success
    gap_then_issue(23, 6, 3, 2, 7, 4, 3);     // two retries then success with early glitch

    // Reset while in WAIT_LCK, then a normal request.
    repeat (2) @(negedge clock);
    issue(40, 41, 42, 0, 5, 10, 0, 13);
    gap_then_issue(40, 41, 42, 0, 4, 6, 0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        m = cur_m; n = cur_n; c = cur_c;
      end else begin
        m = $urandom_range(0, 255); n = $urandom_range(0, 255); c = $urandom_range(0, 255);
      end
      f = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      s = $urandom_range(0, 20);
      l = $urandom_range(0, 30);
      g = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0;
      gap_then_issue(m, n, c, f, s, l, g);
    end

    repeat (30) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #900000;
    nfail++;
    $display("FAIL watchdog: reached cycle %0d, required finish before 90000", cyc);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $fatal(1, "watchdog expired");
  end

endmodule
